// File: rtl/mode_arb_pkg.sv
// Shared types and default thresholds for the BASE/ARITH mode arbiter.
package mode_arb_pkg;

  typedef enum logic [2:0] {
    BASE        = 3'd0,
    DRAIN_ENTER = 3'd1,
    ARITH       = 3'd2,
    DRAIN_EXIT  = 3'd3,
    COOLDOWN    = 3'd4
  } state_t;

  typedef enum logic {
    MODE_BASE  = 1'b0,
    MODE_ARITH = 1'b1
  } mode_t;

  localparam logic [7:0] DEF_ENTER_CONF    = 8'd24;
  localparam logic [7:0] DEF_EXIT_CONF     = 8'd12;
  localparam logic [7:0] DEF_MIN_RUNLEN    = 8'd6;
  localparam int         DEF_ENTER_HOLD    = 4;
  localparam int         DEF_EXIT_HOLD     = 4;
  localparam int         DEF_MIN_DWELL     = 16;
  localparam int         DEF_DRAIN_TIMEOUT = 32;
  localparam int         DEF_COOLDOWN_CYC  = 8;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hold_counter.sv
// Consecutive-true saturating counter; done fires on the N-th consecutive
// true cycle so the caller can act at that edge.
module hold_counter #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cond,
  input  logic clear,
  output logic done
);

  localparam int W = $clog2(N + 1);

  logic [W-1:0] ctr;

  // NOTE: sequential state is written only with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr <= '0;
    end else if (clear || !cond) begin
      ctr <= '0;
    end else if (ctr != W'(N)) begin
      ctr <= ctr + W'(1);
    end
  end

  assign done = cond && (ctr == W'(N - 1));

endmodule

// File: rtl/mode_arbiter.sv
// Hysteresis-gated switch between BASE and ARITH datapaths with a
// stall/empty drain handshake, minimum dwell and post-exit cooldown.
module mode_arbiter
  import mode_arb_pkg::*;
#(
  parameter logic [7:0] ENTER_CONF    = DEF_ENTER_CONF,
  parameter logic [7:0] EXIT_CONF     = DEF_EXIT_CONF,
  parameter logic [7:0] MIN_RUNLEN    = DEF_MIN_RUNLEN,
  parameter int         ENTER_HOLD    = DEF_ENTER_HOLD,
  parameter int         EXIT_HOLD     = DEF_EXIT_HOLD,
  parameter int         MIN_DWELL     = DEF_MIN_DWELL,
  parameter int         DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
  parameter int         COOLDOWN_CYC  = DEF_COOLDOWN_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        wa_req,
  input  logic [7:0]  confidence,
  input  logic [7:0]  predicted_runlen,
  input  logic        force_base,
  input  logic        pipe_empty,
  output logic        mode,
  output logic        stall_req,
  output logic        mode_switch,
  output logic        abort,
  output logic [2:0]  state_o,
  output logic [15:0] switch_cnt
);

  localparam int DRW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int DWW = $clog2(MIN_DWELL + 1);
  localparam int CLW = $clog2(COOLDOWN_CYC + 1);

  state_t         state;
  mode_t          mode_r;
  logic [DRW-1:0] drain_ctr;
  logic [DWW-1:0] dwell_ctr;
  logic [CLW-1:0] cool_ctr;

  logic enter_q, exit_q, dwell_done;
  logic enter_done, exit_done, leave_arith;

  assign enter_q    = en && wa_req && (confidence >= ENTER_CONF) &&
                      (predicted_runlen >= MIN_RUNLEN);
  assign exit_q     = confidence < EXIT_CONF;
  assign dwell_done = dwell_ctr == DWW'(MIN_DWELL);

  // Exit hysteresis only starts once dwell is met, so a low-confidence
  // stretch during dwell cannot saturate the counter past its trigger.
  hold_counter #(.N(ENTER_HOLD)) u_enter_hold (
    .clk   (clk),
    .rst   (rst),
    .cond  ((state == BASE) && enter_q),
    .clear (enter_done),
    .done  (enter_done)
  );

  hold_counter #(.N(EXIT_HOLD)) u_exit_hold (
    .clk   (clk),
    .rst   (rst),
    .cond  ((state == ARITH) && dwell_done && exit_q),
    .clear (leave_arith),
    .done  (exit_done)
  );

  assign leave_arith = (state == ARITH) && (force_base || !en || exit_done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BASE;
      mode_r      <= MODE_BASE;
      mode_switch <= 1'b0;
      abort       <= 1'b0;
      switch_cnt  <= '0;
      drain_ctr   <= '0;
      dwell_ctr   <= '0;
      cool_ctr    <= '0;
    end else begin
      mode_switch <= 1'b0;
      abort       <= 1'b0;
      case (state)
        BASE: begin
          if (enter_done) state <= DRAIN_ENTER;
        end
        DRAIN_ENTER: begin
          if (force_base || !en) begin
            state     <= COOLDOWN;
            abort     <= 1'b1;
            drain_ctr <= '0;
          end else if (pipe_empty) begin
            state       <= ARITH;
            mode_r      <= MODE_ARITH;
            mode_switch <= 1'b1;
            switch_cnt  <= sat_inc16(switch_cnt);
            drain_ctr   <= '0;
          end else if (drain_ctr == DRW'(DRAIN_TIMEOUT - 1)) begin
            state     <= COOLDOWN;
            abort     <= 1'b1;
            drain_ctr <= '0;
          end else begin
            drain_ctr <= drain_ctr + DRW'(1);
          end
        end
        ARITH: begin
          if (leave_arith) begin
            state     <= DRAIN_EXIT;
            dwell_ctr <= '0;
          end else if (!dwell_done) begin
            dwell_ctr <= dwell_ctr + DWW'(1);
          end
        end
        DRAIN_EXIT: begin
          if (pipe_empty) begin
            state       <= COOLDOWN;
            mode_r      <= MODE_BASE;
            mode_switch <= 1'b1;
            switch_cnt  <= sat_inc16(switch_cnt);
          end
        end
        COOLDOWN: begin
          if (cool_ctr == CLW'(COOLDOWN_CYC - 1)) begin
            state    <= BASE;
            cool_ctr <= '0;
          end else begin
            cool_ctr <= cool_ctr + CLW'(1);
          end
        end
        default: state <= BASE;
      endcase
    end
  end

  assign mode      = (mode_r == MODE_ARITH);
  assign stall_req = (state == DRAIN_ENTER) || (state == DRAIN_EXIT);
  assign state_o   = state;

endmodule
